muldiv_ctl: RTL and testbench
=============================

MULDIV_CTL -- requirements
Module: muldiv_ctl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port pause_i, input, 1 bit: pipeline freeze; op_i is ignored while pause_i is high.
REQ-004 The block SHALL have the port op_i, input, 4 bits: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; codes 9-15 are NOP.
REQ-005 The block SHALL have the port a_i, input, 32 bits: rs operand (multiplicand or dividend; MTHI/MTLO data).
REQ-006 The block SHALL have the port b_i, input, 32 bits: rt operand (multiplier or divisor).
REQ-007 The block SHALL have the port res_o, output, 32 bits: HI for MFHI, LO for MFLO, otherwise 0; combinational.
REQ-008 The block SHALL have the port busy_o, output, 1 bit: an iterative operation is in progress.
REQ-009 The block SHALL have the port stall_o, output, 1 bit: pipeline hold request.
REQ-010 The block SHALL have the ports hi_o and lo_o, output, 32 bits each: architectural HI and LO registers.

Function
REQ-011 The FSM SHALL have the states IDLE, MUL, DIV and FIX; only IDLE has busy_o=0.
REQ-012 An op is accepted at the rising edge of cycle T when pause_i=0, busy_o=0 and op_i is one of codes 1-8.
REQ-013 Accepting MULT/MULTU SHALL enter MUL; accepting DIV/DIVU SHALL enter DIV; both latch operand magnitudes and the signedness.
REQ-014 MUL SHALL perform 32 radix-2 shift/add iterations; DIV SHALL perform 32 restoring shift/subtract iterations; a 6-bit counter runs 0..31.
REQ-015 FIX SHALL last 1 cycle, apply the sign correction, write HI/LO and return to IDLE.
REQ-016 busy_o SHALL be high for cycles T+1..T+33; the new HI/LO SHALL be visible from cycle T+34.
REQ-017 MULT SHALL produce the signed 64-bit product {HI,LO}; MULTU SHALL produce the unsigned 64-bit product.
REQ-018 DIV SHALL give LO=quotient truncated toward zero and HI=remainder carrying the sign of a_i.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 DIV or DIVU with b_i=0 SHALL give LO=0xFFFFFFFF and HI=a_i, with no exception.
REQ-021 MTHI/MTLO SHALL write a_i into HI/LO at the accept edge and SHALL NOT set busy_o.
REQ-022 MFHI/MFLO SHALL drive res_o from HI/LO in the same cycle when busy_o=0.
REQ-023 stall_o SHALL equal (op_i in 1..8) AND busy_o AND NOT pause_i; a stalled op is not accepted and SHALL be re-presented by the pipeline.
REQ-024 pause_i high while busy SHALL NOT halt the iterations.
REQ-025 No new op is accepted until busy_o=0; in cycle T+34 the block is IDLE and accepts normally.
REQ-026 Total occupancy SHALL NOT exceed 34 cycles, within the 35-cycle pause-free window the pipeline guarantees after a mult/div.

Reset
REQ-027 rst high at a clock edge SHALL force IDLE, HI=LO=0, counter=0, busy_o=0 and stall_o=0.
REQ-028 rst SHALL abort any in-progress operation with no HI/LO update.
REQ-029 rst SHALL override any op_i presented in the same cycle.

Configuration
REQ-030 The macro MULDIV_DIV_EN SHALL compile divide support in.
REQ-031 With MULDIV_DIV_EN defined, behaviour SHALL be as specified above.
REQ-032 Without MULDIV_DIV_EN, the DIV state and the subtractor SHALL be absent; DIV/DIVU SHALL be accepted as NOP with HI/LO unchanged and busy_o remaining 0.

Verification
REQ-033 MULT a=0xFFFFFFFF b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE at T+34; busy_o high exactly for T+1..T+33.
REQ-034 MULTU a=0xFFFFFFFF b=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7 b=0 -> LO=0xFFFFFFFF, HI=7.
REQ-036 MFLO presented from T+5 after MULT 3*4 -> stall_o high for T+5..T+33 (29 cycles); at T+34 stall_o=0 and res_o=0x0000000C.
REQ-037 rst pulsed at T+10 of a DIV -> busy_o=0 and HI=LO=0 in the next cycle; a following MTLO 0x1234 gives lo_o=0x1234 with busy_o=0.
REQ-038 pause_i held high for T+2..T+20 during a MULT -> result still visible at T+34; with MULDIV_DIV_EN undefined, DIV leaves HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_ctl.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift/add multiply, restoring divide.
// Define MULDIV_DIV_EN to build in divide support; without it DIV/DIVU act as NOP.
//
// state | meaning
// IDLE  | waiting for an op; MTHI/MTLO/MFHI/MFLO complete here
// MUL   | 32 shift/add steps on the operand magnitudes
// DIV   | 32 restoring shift/subtract steps (MULDIV_DIV_EN only)
// FIX   | sign correction, HI/LO write-back
module muldiv_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o,
  output logic        busy_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
`ifdef MULDIV_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'd4;
`endif
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd2, S_DIV = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd2} state_t;
`endif

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] acc;     // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
  logic [31:0] opd;     // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic        neg_lo;
`ifdef MULDIV_DIV_EN
  logic        neg_hi;
  logic        is_div;
  logic [32:0] div_diff;
`endif

  logic        op_valid;
  logic        accept;
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] mul_sum;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    op_valid  = (op_i != 4'd0) && (op_i <= 4'd8);
    accept    = op_valid && !busy_o && !pause_i;
    stall_o   = op_valid && busy_o && !pause_i;
    signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    a_neg     = signed_op & a_i[31];
    b_neg     = signed_op & b_i[31];
    a_abs     = a_neg ? (32'd0 - a_i) : a_i;
    b_abs     = b_neg ? (32'd0 - b_i) : b_i;
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opd : 32'd0)};
`ifdef MULDIV_DIV_EN
    div_diff  = acc[63:31] - {1'b0, opd};
`endif

    if (op_i == OP_MFHI)      res_o = hi_o;
    else if (op_i == OP_MFLO) res_o = lo_o;
    else                      res_o = 32'd0;

    {fix_hi, fix_lo} = neg_lo ? (64'd0 - acc) : acc;
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      // Quotient and remainder get independent sign fixes; a zero divisor
      // leaves the all-ones quotient alone and the remainder restores a_i.
      fix_lo = neg_lo ? (32'd0 - acc[31:0]) : acc[31:0];
      fix_hi = neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_o <= 1'b0;
      cnt    <= 6'd0;
      acc    <= 64'd0;
      opd    <= 32'd0;
      neg_lo <= 1'b0;
      hi_o   <= 32'd0;
      lo_o   <= 32'd0;
`ifdef MULDIV_DIV_EN
      neg_hi <= 1'b0;
      is_div <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                state  <= S_MUL;
                busy_o <= 1'b1;
                cnt    <= 6'd0;
                acc    <= {32'd0, b_abs};
                opd    <= a_abs;
                neg_lo <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                is_div <= 1'b0;
`endif
              end
`ifdef MULDIV_DIV_EN
              OP_DIV, OP_DIVU: begin
                state  <= S_DIV;
                busy_o <= 1'b1;
                cnt    <= 6'd0;
                acc    <= {32'd0, a_abs};
                opd    <= b_abs;
                neg_lo <= (a_neg ^ b_neg) && (b_i != 32'd0);
                neg_hi <= a_neg;
                is_div <= 1'b1;
              end
`endif
              OP_MTHI: hi_o <= a_i;
              OP_MTLO: lo_o <= a_i;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= S_FIX;
            cnt   <= 6'd0;
          end
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          if (!div_diff[32]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
          else               acc <= {acc[62:0], 1'b0};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= S_FIX;
            cnt   <= 6'd0;
          end
        end
`endif
        S_FIX: begin
          hi_o   <= fix_hi;
          lo_o   <= fix_lo;
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctl.sv
// Bench for muldiv_ctl: arithmetic reference model checked every cycle, plus
// literal HI/LO/busy expectations for directed vectors. Honours MULDIV_DIV_EN.
module tb_muldiv_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic [31:0] res_o;
  logic        busy_o;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  muldiv_ctl dut (
    .clk(clk), .rst(rst), .pause_i(pause_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .res_o(res_o), .busy_o(busy_o), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {HI, LO}.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (op)
      4'd1: begin r = sa * sb; res = r; end
      4'd2: res = {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      4'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Model: remaining busy cycles, pending result, architectural HI/LO.
  int          m_cnt = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    chk_en = 1'b1;
    if (rst) begin
      m_cnt = 0; m_hi = 32'd0; m_lo = 32'd0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (!pause_i) begin
      case (op_i)
        4'd1, 4'd2: begin {p_hi, p_lo} = ref_result(op_i, a_i, b_i); m_cnt = 33; end
        4'd3, 4'd4: if (DIV_ON) begin {p_hi, p_lo} = ref_result(op_i, a_i, b_i); m_cnt = 33; end
        4'd7: m_hi = a_i;
        4'd8: m_lo = a_i;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic        e_busy, e_stall;
    logic [31:0] e_res;
    if (chk_en) begin
      e_busy  = (m_cnt > 0);
      e_stall = (op_i >= 4'd1) && (op_i <= 4'd8) && e_busy && !pause_i;
      e_res   = (op_i == 4'd5) ? m_hi : (op_i == 4'd6) ? m_lo : 32'd0;
      chk("cyc_busy", busy_o, e_busy);
      chk("cyc_stall", stall_o, e_stall);
      chk("cyc_hi", hi_o, m_hi);
      chk("cyc_lo", lo_o, m_lo);
      chk("cyc_res", res_o, e_res);
    end
  end

  // Present one op for one cycle, then observe cycles T+1..T+33 with an optional
  // pause window [pf,pt], and check literals in cycle T+34.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int ebusy, input int pf, input int pt);
    int nb;
    op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    op_i = 4'd0;
    nb = 0;
    for (int k = 1; k <= 33; k++) begin
      pause_i = (k >= pf) && (k <= pt);
      @(negedge clk);
      if (busy_o) nb++;
      @(posedge clk); #1;
    end
    pause_i = 1'b0;
    chk({name, "_busycycles"}, nb, ebusy);
    chk({name, "_busy_end"}, busy_o, 1'b0);
    chk({name, "_hi"}, hi_o, eh);
    chk({name, "_lo"}, lo_o, el);
  endtask

  initial begin
    int n;
    logic [31:0] kh, kl;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);

    run_op("mult_neg1x2", 4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, -1);
    run_op("multu_ffx2", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 33, 0, -1);
    run_op("mult_min2", 4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, 0, -1);
    run_op("mult_pause", 4'd1, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 2, 20);

    kh = 32'hFFFF_FFFF; kl = 32'hFFFF_FFF1;
    run_op("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2,
           DIV_ON ? 32'hFFFF_FFFF : kh, DIV_ON ? 32'hFFFF_FFFD : kl, DIV_ON ? 33 : 0, 0, -1);
    run_op("divu_7_0", 4'd4, 32'd7, 32'd0,
           DIV_ON ? 32'd7 : kh, DIV_ON ? 32'hFFFF_FFFF : kl, DIV_ON ? 33 : 0, 0, -1);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF,
           DIV_ON ? 32'd0 : kh, DIV_ON ? 32'h8000_0000 : kl, DIV_ON ? 33 : 0, 0, -1);
    run_op("divu_100_7", 4'd4, 32'd100, 32'd7,
           DIV_ON ? 32'd2 : kh, DIV_ON ? 32'd14 : kl, DIV_ON ? 33 : 0, 0, -1);
    run_op("div_7_m2", 4'd3, 32'd7, 32'hFFFF_FFFE,
           DIV_ON ? 32'd1 : kh, DIV_ON ? 32'hFFFF_FFFD : kl, DIV_ON ? 33 : 0, 0, -1);
    run_op("div_neg_by0", 4'd3, 32'hFFFF_FFF0, 32'd0,
           DIV_ON ? 32'hFFFF_FFF0 : kh, DIV_ON ? 32'hFFFF_FFFF : kl, DIV_ON ? 33 : 0, 0, -1);

    // MFLO presented from T+5 of a MULT 3*4: stalls T+5..T+33.
    op_i = 4'd1; a_i = 32'd3; b_i = 32'd4;
    @(posedge clk); #1;
    op_i = 4'd0;
    repeat (4) begin @(posedge clk); #1; end
    op_i = 4'd6;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      n++;
      @(posedge clk); #1;
    end
    chk("mflo_stall_cycles", n, 29);
    chk("mflo_stall_end", stall_o, 1'b0);
    chk("mflo_res", res_o, 32'h0000_000C);
    @(posedge clk); #1;
    op_i = 4'd0;

    // MTHI / MTLO take effect at the accept edge, no busy.
    op_i = 4'd7; a_i = 32'hAAAA_5555;
    @(posedge clk); #1;
    chk("mthi_hi", hi_o, 32'hAAAA_5555);
    chk("mthi_busy", busy_o, 1'b0);
    op_i = 4'd8; a_i = 32'h1234_5678;
    @(posedge clk); #1;
    chk("mtlo_lo", lo_o, 32'h1234_5678);
    op_i = 4'd5;
    @(negedge clk);
    chk("mfhi_res", res_o, 32'hAAAA_5555);
    @(posedge clk); #1;
    op_i = 4'd0;

    // Reset at T+10 of a divide aborts it and overrides a concurrent MTHI.
    op_i = 4'd4; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk); #1;
    op_i = 4'd0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1; op_i = 4'd7; a_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst = 1'b0; op_i = 4'd0;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_hi", hi_o, 32'd0);
    chk("abort_lo", lo_o, 32'd0);
    op_i = 4'd8; a_i = 32'h0000_1234;
    @(posedge clk); #1;
    op_i = 4'd0;
    chk("post_rst_mtlo", lo_o, 32'h0000_1234);
    chk("post_rst_busy", busy_o, 1'b0);

    run_op("mult_3x4", 4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 33, 0, -1);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
